wb_arbiter_2m: RTL and testbench
================================

Name: wb_arbiter_2m

Overview:
Two-master to one-slave Wishbone classic arbiter. It lets the core's instruction port (m0) and data port (m1) share a single unified memory or peripheral slave. Requests are granted round-robin and held for the whole bus cycle. A watchdog terminates stalled strobes with an error, so a hung slave raises a fault instead of freezing the core.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width; SEL_W = DATA_W/8
TIMEOUT, 255, cycles a strobe may wait for ack/err before the arbiter errors it; 0 disables the watchdog

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
m0_adr_i  in  ADDR_W  master 0 (instruction) address
m0_dat_i  in  DATA_W  master 0 write data
m0_dat_o  out  DATA_W  master 0 read data
m0_we_i  in  1  master 0 write enable
m0_sel_i  in  SEL_W  master 0 byte select
m0_cyc_i, m0_stb_i  in  1  master 0 cycle / strobe
m0_ack_o, m0_err_o  out  1  master 0 acknowledge / error
m1_*  same set as m0_*  master 1 (data)
s_adr_o, s_dat_o, s_we_o, s_sel_o, s_cyc_o, s_stb_o  out  as above  slave side
s_dat_i  in  DATA_W  slave read data
s_ack_i, s_err_i  in  1  slave acknowledge / error
grant_o  out  2  one-hot current grant (bit0 = m0, bit1 = m1); 00 when idle
timeout_o  out  1  one-cycle pulse when the watchdog fires

Behaviour:
- Reset: rst_n is asynchronous and active-low; clock is clk. Reset forces state IDLE, last_grant = m1 (so m0 wins the first tie), and the watchdog count to 0. All outputs are 0 while in reset and in IDLE.
- States: IDLE, GNT0, GNT1. The state is registered; all slave-side outputs are combinational muxes of the granted master.
- IDLE: a master is requesting when cyc_i=1 and stb_i=1.
  - Only one master requesting -> go to that master's GNT state at the next edge.
  - Both requesting -> grant the master that is not last_grant.
  - On entering GNTx, last_grant is set to x.
- Grant latency: one cycle from request to s_cyc_o. A slave ack can therefore reach the master no earlier than the cycle after grant.
- GNTx forwarding:
  - s_adr_o, s_dat_o, s_we_o, s_sel_o, s_cyc_o and s_stb_o follow mx.
  - mx_dat_o = s_dat_i. The non-granted master's dat_o is 0.
  - mx_ack_o = s_ack_i and mx_err_o = s_err_i, gated by mx_cyc_i.
  - The non-granted master sees ack=0 and err=0 at all times.
- Release: when mx_cyc_i=0 in GNTx, the next state is IDLE. s_cyc_o drops in that same cycle because it is combinational.
  - A master holding cyc across several strobes keeps the grant and is never interleaved.
  - No direct GNT0->GNT1 transfer: the path always goes through IDLE, which costs one idle cycle.
- Watchdog (TIMEOUT>0):
  - cnt (width clog2(TIMEOUT+1)) increments each GNT cycle with the granted stb=1, s_ack_i=0 and s_err_i=0.
  - cnt clears on ack, on err, on stb=0, or in IDLE.
  - When cnt==TIMEOUT, in that same cycle: mx_err_o=1, s_stb_o is forced to 0, and timeout_o=1. cnt clears at the next edge.
  - The grant is held until the master drops cyc.
- Simultaneous events:
  - s_ack_i and s_err_i both high -> forward both unchanged; the master resolves them.
  - A slave ack in the same cycle cnt reaches TIMEOUT -> the ack wins and no timeout fires.
  - A slave ack arriving while granted cyc=0 -> discarded.
- Reset mid-transfer: outputs go to 0 immediately (asynchronous) and the in-flight transfer is abandoned. After rst_n rises, arbitration restarts from IDLE with m0 favoured.

Test Plan:
1. Single m0 read: m0 cyc/stb at adr 0x10, slave acks 1 cycle after s_stb_o with dat 0x00000013 -> grant_o=01 one cycle after request; m0_ack_o=1 with m0_dat_o=0x00000013; m1_ack_o stays 0.
2. Tie after reset: m0 and m1 request in the same cycle -> m0 granted first. m0 drops cyc -> one IDLE cycle -> grant_o=10 for m1. Then m0 re-requests while m1 holds cyc -> m0 waits until m1 releases.
3. Locked burst: m1 keeps cyc high over two strobes (write 0x00001000 to 0x100, then read 0x100) while m0 requests throughout -> grant_o stays 10 for both transfers; the read returns 0x00001000; m0 is granted only after m1 cyc=0.
4. Watchdog: TIMEOUT=8, m0 strobe, slave never acks -> m0_err_o and timeout_o pulse on the 9th stalled cycle, with s_stb_o=0 in that cycle. Repeating with an ack on the 9th cycle -> ack delivered and no timeout.
5. Error pass-through: the slave asserts s_err_i for an m1 store -> m1_err_o=1 in the same cycle; m0 is unaffected; timeout_o=0.
6. Reset mid-transfer: rst_n low while in GNT1 with stb pending -> s_cyc_o, s_stb_o and grant_o are 0 immediately. After release, a simultaneous request grants m0 first.

Source files
------------

// File: rtl/wb_arbiter_2m_if.sv
// Wishbone classic bus bundle shared by the arbiter's master and slave ports.
//   adr, dat_w, we, sel, cyc, stb : driven by the bus master
//   dat_r, ack, err               : driven by the bus slave
// The master modport is for the side that originates cycles; the slave modport
// is for the side that answers them.
interface wb_arbiter_2m_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) ();
  localparam int unsigned SEL_W = DATA_W / 8;

  logic [ADDR_W-1:0] adr;
  logic [DATA_W-1:0] dat_w;
  logic [DATA_W-1:0] dat_r;
  logic              we;
  logic [SEL_W-1:0]  sel;
  logic              cyc;
  logic              stb;
  logic              ack;
  logic              err;

  modport master (output adr, dat_w, we, sel, cyc, stb, input dat_r, ack, err);
  modport slave  (input adr, dat_w, we, sel, cyc, stb, output dat_r, ack, err);
endinterface

// File: rtl/wb_arbiter_2m.sv
// Two-master to one-slave Wishbone classic arbiter with round-robin grant,
// grant held for the whole bus cycle, and a stall watchdog.
//   clk, rst_n : clock, asynchronous active-low reset
//   m0         : instruction master port (slave modport)
//   m1         : data master port (slave modport)
//   s          : shared slave port (master modport)
//   grant      : one-hot current owner (bit0 = m0, bit1 = m1), 00 when idle
//   timeout    : one-cycle pulse when the watchdog terminates a strobe
module wb_arbiter_2m #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  wb_arbiter_2m_if.slave         m0,
  wb_arbiter_2m_if.slave         m1,
  wb_arbiter_2m_if.master        s,
  output logic [1:0]             grant,
  output logic                   timeout
);
  localparam int unsigned SEL_W = DATA_W / 8;
  localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
  localparam bit WD_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t            state;
  logic              last_m1;
  logic [CNT_W-1:0]  cnt;

  logic              req0;
  logic              req1;
  logic              g0;
  logic              g1;
  logic [ADDR_W-1:0] x_adr;
  logic [DATA_W-1:0] x_dat;
  logic              x_we;
  logic [SEL_W-1:0]  x_sel;
  logic              x_cyc;
  logic              x_stb;
  logic              at_limit;
  logic              stall;
  logic              fire;

  assign req0 = m0.cyc & m0.stb;
  assign req1 = m1.cyc & m1.stb;
  assign g0   = (state == GNT0);
  assign g1   = (state == GNT1);

  // Select the granted master's request; everything is zero while idle.
  always_comb begin : req_mux
    x_adr = '0;
    x_dat = '0;
    x_we  = 1'b0;
    x_sel = '0;
    x_cyc = 1'b0;
    x_stb = 1'b0;
    if (g0) begin
      x_adr = m0.adr;
      x_dat = m0.dat_w;
      x_we  = m0.we;
      x_sel = m0.sel;
      x_cyc = m0.cyc;
      x_stb = m0.stb;
    end else if (g1) begin
      x_adr = m1.adr;
      x_dat = m1.dat_w;
      x_we  = m1.we;
      x_sel = m1.sel;
      x_cyc = m1.cyc;
      x_stb = m1.stb;
    end
  end

  // A slave termination in the limit cycle beats the watchdog. The strobe is
  // withdrawn from the slave on the limit cycle regardless, so the slave's
  // ack never feeds back into s.stb.
  assign at_limit = WD_EN && (g0 | g1) && (cnt == CNT_MAX);
  assign stall    = x_cyc & x_stb & ~s.ack & ~s.err;
  assign fire     = at_limit & stall;

  assign s.adr   = x_adr;
  assign s.dat_w = x_dat;
  assign s.we    = x_we;
  assign s.sel   = x_sel;
  assign s.cyc   = x_cyc;
  assign s.stb   = x_stb & ~at_limit;

  // Responses go only to the owner, and only while it still holds cyc.
  assign m0.dat_r = g0 ? s.dat_r : '0;
  assign m0.ack   = g0 & m0.cyc & s.ack;
  assign m0.err   = g0 & m0.cyc & (s.err | fire);
  assign m1.dat_r = g1 ? s.dat_r : '0;
  assign m1.ack   = g1 & m1.cyc & s.ack;
  assign m1.err   = g1 & m1.cyc & (s.err | fire);

  assign grant   = {g1, g0};
  assign timeout = fire;

  // Ownership, round-robin history and watchdog count.
  always_ff @(posedge clk or negedge rst_n) begin : ctrl
    if (!rst_n) begin
      state   <= IDLE;
      last_m1 <= 1'b1;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (req0 && (!req1 || last_m1)) begin
            state   <= GNT0;
            last_m1 <= 1'b0;
          end else if (req1) begin
            state   <= GNT1;
            last_m1 <= 1'b1;
          end
        end
        GNT0, GNT1: begin
          if (!x_cyc) begin
            state <= IDLE;
          end
          if (WD_EN && stall && !at_limit) begin
            cnt <= cnt + CNT_W'(1);
          end else begin
            cnt <= '0;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Self-checking bench for wb_arbiter_2m: directed scenarios with literal
// expectations, then random masters against a reactive slave, all compared
// every cycle with an ownership-level reference model.
module tb_wb_arbiter_2m;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned SEL_W   = DATA_W / 8;
  localparam int unsigned TIMEOUT = 8;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] grant;
  logic       timeout;

  always #5 clk = ~clk;

  wb_arbiter_2m_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m0 ();
  wb_arbiter_2m_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m1 ();
  wb_arbiter_2m_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) s ();

  wb_arbiter_2m #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .m0      (m0),
    .m1      (m1),
    .s       (s),
    .grant   (grant),
    .timeout (timeout)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- slave behaviour (configurable latency / response) ------
  int cfg_lat   = 1;   // cycles of stb before responding, -1 = never
  bit cfg_err   = 1'b0;
  bit cfg_force = 1'b0; // drive ack regardless of stb
  bit rnd_slave = 1'b0;
  logic [31:0] mem [256];

  initial begin : slave
    int cnt;
    int lat;
    int kind;
    logic [7:0] idx;
    for (int i = 0; i < 256; i++) mem[i] = 32'(i) * 32'h0101_0101;
    mem[4] = 32'h0000_0013;
    cnt = 0; lat = 0; kind = 0;
    s.ack = 1'b0; s.err = 1'b0; s.dat_r = '0;
    forever begin
      @(posedge clk); #2;
      s.ack = 1'b0; s.err = 1'b0; s.dat_r = '0;
      if (rst_n && s.stb) begin
        if (cnt == 0) begin
          if (rnd_slave) begin
            lat  = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 3));
            kind = int'($urandom_range(0, 9));
            kind = (kind == 0) ? 1 : (kind == 1) ? 2 : 0;
          end else begin
            lat  = cfg_lat;
            kind = cfg_err ? 1 : 0;
          end
        end
        if (cnt == lat) begin
          idx = s.adr[9:2];
          cnt = 0;
          if (kind == 1) begin
            s.err = 1'b1;
          end else if (kind == 2) begin
            s.ack = 1'b1;
            s.err = 1'b1;
          end else begin
            s.ack = 1'b1;
            if (s.we) begin
              for (int b = 0; b < 4; b++)
                if (s.sel[b]) mem[idx][8*b +: 8] = s.dat_w[8*b +: 8];
            end else begin
              s.dat_r = mem[idx];
            end
          end
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
      if (cfg_force) s.ack = 1'b1;
    end
  end

  // ---------------- reference model + per-cycle compare ---------------------
  // owner: 0 nobody, 1 m0, 2 m1. last: index of most recent owner.
  // waited: consecutive unanswered strobe cycles of the current owner.
  int owner  = 0;
  int last   = 1;
  int waited = 0;

  always @(negedge clk) begin : scoreboard
    logic              xc, xs, xw, to, fire, req0, req1;
    logic [ADDR_W-1:0] xa;
    logic [DATA_W-1:0] xd;
    logic [SEL_W-1:0]  xl;
    logic [1:0]        eg;
    if (!rst_n) begin
      owner = 0; last = 1; waited = 0;
    end
    xc = 1'b0; xs = 1'b0; xw = 1'b0; xa = '0; xd = '0; xl = '0;
    if (owner == 1) begin
      xc = m0.cyc; xs = m0.stb; xw = m0.we; xa = m0.adr; xd = m0.dat_w; xl = m0.sel;
    end else if (owner == 2) begin
      xc = m1.cyc; xs = m1.stb; xw = m1.we; xa = m1.adr; xd = m1.dat_w; xl = m1.sel;
    end
    to   = (owner != 0) && (TIMEOUT != 0) && (waited == int'(TIMEOUT));
    fire = to && xc && xs && !s.ack && !s.err;
    eg   = (owner == 1) ? 2'b01 : (owner == 2) ? 2'b10 : 2'b00;

    chk("grant", grant, eg);
    chk("timeout", timeout, fire);
    chk("s_cyc", s.cyc, xc);
    chk("s_stb", s.stb, xs && !to);
    chk("s_adr", s.adr, xa);
    chk("s_dat", s.dat_w, xd);
    chk("s_we", s.we, xw);
    chk("s_sel", s.sel, xl);
    chk("m0_ack", m0.ack, (owner == 1) && m0.cyc && s.ack);
    chk("m0_err", m0.err, (owner == 1) && m0.cyc && (s.err || fire));
    chk("m0_dat", m0.dat_r, (owner == 1) ? s.dat_r : '0);
    chk("m1_ack", m1.ack, (owner == 2) && m1.cyc && s.ack);
    chk("m1_err", m1.err, (owner == 2) && m1.cyc && (s.err || fire));
    chk("m1_dat", m1.dat_r, (owner == 2) ? s.dat_r : '0);

    if (rst_n) begin
      req0 = m0.cyc && m0.stb;
      req1 = m1.cyc && m1.stb;
      if (owner == 0) begin
        waited = 0;
        if (req0 && (!req1 || last == 1)) begin
          owner = 1; last = 0;
        end else if (req1) begin
          owner = 2; last = 1;
        end
      end else if (!xc) begin
        owner = 0; waited = 0;
      end else if (xs && !s.ack && !s.err && !to) begin
        waited++;
      end else begin
        waited = 0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------------------------------
  task automatic drv(input int m, input bit cyc, input bit stb, input bit we,
                     input logic [31:0] adr, input logic [31:0] dat,
                     input logic [3:0] sel = 4'hf);
    if (m == 0) begin
      m0.cyc = cyc; m0.stb = stb; m0.we = we; m0.adr = adr; m0.dat_w = dat; m0.sel = sel;
    end else begin
      m1.cyc = cyc; m1.stb = stb; m1.we = we; m1.adr = adr; m1.dat_w = dat; m1.sel = sel;
    end
  endtask

  task automatic go();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    go(); rst_n = 1'b0;
    go(); go(); rst_n = 1'b1;
  endtask

  int nleft [2];

  task automatic rand_drv(input int i);
    drv(i, 1'b1, 1'b1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)) << 2,
        $urandom, 4'($urandom_range(1, 15)));
  endtask

  task automatic rand_master(input int i, input bit term);
    bit c, st;
    c  = (i == 0) ? m0.cyc : m1.cyc;
    st = (i == 0) ? m0.stb : m1.stb;
    if (!c) begin
      if ($urandom_range(0, 3) == 0) begin
        nleft[i] = int'($urandom_range(1, 3));
        rand_drv(i);
      end else begin
        drv(i, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      end
    end else if (st) begin
      if (term) begin
        nleft[i]--;
        if (nleft[i] <= 0)                 drv(i, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        else if ($urandom_range(0, 1) == 1) rand_drv(i);
        else                               drv(i, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      end else if ($urandom_range(0, 49) == 0) begin
        // abandon the cycle with the strobe still up
        drv(i, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
      end
    end else begin
      rand_drv(i);
    end
  endtask

  task automatic rand_phase(input int ncyc);
    bit t0, t1;
    for (int c = 0; c < ncyc; c++) begin
      smp();
      t0 = m0.ack | m0.err;
      t1 = m1.ack | m1.err;
      go();
      rand_master(0, t0);
      rand_master(1, t1);
    end
  endtask

  // ---------------- main sequence -------------------------------------------
  initial begin : main
    drv(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drv(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1 rst_n = 1'b0;
    smp();
    chk("rst_grant", grant, 2'b00);
    chk("rst_scyc", s.cyc, 1'b0);
    go(); go(); rst_n = 1'b1;

    // single m0 read, slave answers one cycle after the strobe
    cfg_lat = 1;
    drv(0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0);
    smp(); chk("t1_idle_grant", grant, 2'b00);
    go();  smp(); chk("t1_grant", grant, 2'b01); chk("t1_sstb", s.stb, 1'b1);
    go();  smp(); chk("t1_ack", m0.ack, 1'b1); chk("t1_dat", m0.dat_r, 32'h13);
    chk("t1_m1_ack", m1.ack, 1'b0);
    go();  drv(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    go();

    // tie after reset, release gap, waiting requester
    pulse_reset();
    drv(0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0);
    drv(1, 1'b1, 1'b1, 1'b0, 32'h20, 32'h0);
    smp(); chk("t2_idle", grant, 2'b00);
    go();  smp(); chk("t2_tie_m0", grant, 2'b01);
    go();  smp(); chk("t2_m0_ack", m0.ack, 1'b1);
    go();  drv(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    smp(); chk("t2_rel_grant", grant, 2'b01); chk("t2_rel_scyc", s.cyc, 1'b0);
    go();  smp(); chk("t2_gap", grant, 2'b00);
    go();  drv(0, 1'b1, 1'b1, 1'b0, 32'h14, 32'h0);
    smp(); chk("t2_m1_grant", grant, 2'b10);
    go();  smp(); chk("t2_m1_ack", m1.ack, 1'b1); chk("t2_m0_wait", m0.ack, 1'b0);
    go();  drv(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    smp(); chk("t2_m1_hold", grant, 2'b10);
    go();  smp(); chk("t2_gap2", grant, 2'b00);
    go();  smp(); chk("t2_m0_again", grant, 2'b01);
    go();  smp(); chk("t2_m0_ack2", m0.ack, 1'b1);
    go();  drv(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    // locked burst on m1 while m0 keeps requesting
    go();  cfg_lat = 0;
    drv(1, 1'b1, 1'b1, 1'b1, 32'h100, 32'h0000_1000);
    drv(0, 1'b1, 1'b1, 1'b0, 32'h20, 32'h0);
    smp(); chk("t3_idle", grant, 2'b00);
    go();  smp(); chk("t3_grant_m1", grant, 2'b10); chk("t3_wr_ack", m1.ack, 1'b1);
    go();  drv(1, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0);
    smp(); chk("t3_locked", grant, 2'b10); chk("t3_rd_dat", m1.dat_r, 32'h0000_1000);
    go();  drv(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    smp(); chk("t3_rel", grant, 2'b10); chk("t3_m0_noack", m0.ack, 1'b0);
    go();  smp(); chk("t3_gap", grant, 2'b00);
    go();  smp(); chk("t3_m0_grant", grant, 2'b01);
    go();  drv(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    // slave error passes straight through to m1
    go();  cfg_err = 1'b1;
    drv(1, 1'b1, 1'b1, 1'b1, 32'h40, 32'hdead_beef);
    smp();
    go();  smp(); chk("t5_m1_err", m1.err, 1'b1); chk("t5_m0_err", m0.err, 1'b0);
    chk("t5_to", timeout, 1'b0);
    go();  drv(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0); cfg_err = 1'b0;

    // watchdog fires on the 9th stalled cycle
    go();  cfg_lat = -1;
    drv(0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0);
    smp();
    for (int k = 1; k <= 9; k++) begin
      go(); smp();
      chk("t4_to", timeout, k == 9);
      chk("t4_err", m0.err, k == 9);
      chk("t4_stb", s.stb, k != 9);
    end
    go();  drv(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    go();

    // ack in the limit cycle beats the watchdog
    drv(0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0);
    smp();
    for (int k = 1; k <= 9; k++) begin
      go();
      if (k == 9) cfg_force = 1'b1;
      smp();
      chk("t4b_to", timeout, 1'b0);
      chk("t4b_ack", m0.ack, k == 9);
    end
    go();  cfg_force = 1'b0; drv(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    go();

    // asynchronous reset while m1 owns the bus
    drv(1, 1'b1, 1'b1, 1'b0, 32'h30, 32'h0);
    go();  go(); smp(); chk("t6_pre", grant, 2'b10);
    go();  #2 rst_n = 1'b0; #1;
    chk("t6_scyc", s.cyc, 1'b0); chk("t6_sstb", s.stb, 1'b0); chk("t6_grant", grant, 2'b00);
    drv(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    cfg_lat = 1;
    go();  go();
    drv(0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0);
    drv(1, 1'b1, 1'b1, 1'b0, 32'h20, 32'h0);
    rst_n = 1'b1;
    smp(); chk("t6_idle", grant, 2'b00);
    go();  smp(); chk("t6_m0_first", grant, 2'b01);
    go();  drv(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0); drv(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    go();  go();

    // random traffic against the model
    rnd_slave = 1'b1;
    nleft[0] = 0; nleft[1] = 0;
    rand_phase(3000);
    go();
    drv(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drv(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (4) go();
    smp();
    chk("end_idle", grant, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
